// File: rtl/pwd_pkg.sv
// pwd_pkg: shared state encoding, code geometry and BCD check for the access supervisor
package pwd_pkg;
  localparam int DIGIT_W = 4;
  localparam int CODE_W = 16;
  localparam int NUM_DIGITS = 4;
  typedef enum logic [1:0] {ARMED, OPEN, LOCKOUT, PROG} state_t;
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/tick_down_timer.sv
// tick_down_timer: loadable down-counter stepped by tick; expire flags the tick that reaches zero
module tick_down_timer #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expire
);
  assign expire = tick && !load && value == W'(1);
  always_ff @(posedge clock or negedge rst)
    if (!rst) value <= '0;
    else if (load) value <= load_value;
    else if (tick && value != '0) value <= value - 1'b1;
endmodule

// File: rtl/pwd_access_supervisor.sv
// pwd_access_supervisor: gates keypad entry, counts failures, times lockout/open windows, reprograms the code
module pwd_access_supervisor import pwd_pkg::*; #(
  parameter int                MAX_FAILS    = 3,
  parameter int                LOCK_TICKS   = 30,
  parameter int                OPEN_TICKS   = 12,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int                TMR_W        = 6
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               tick,
  input  logic               attempt_done,
  input  logic               attempt_ok,
  input  logic               prog_req,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  output logic               entry_enable,
  output logic               admitted,
  output logic               locked,
  output logic               prog_active,
  output logic [1:0]         prog_idx,
  output logic [3:0]         fail_count,
  output logic [TMR_W-1:0]   lock_remaining,
  output logic [CODE_W-1:0]  pwd_code
);
  localparam logic [3:0] MF = 4'(MAX_FAILS);
  state_t state, nxt;
  logic ld, expire, acc;
  logic [TMR_W-1:0] ld_val, timer;
  logic [CODE_W-1:0] shadow, shadow_nxt;
  tick_down_timer #(.W(TMR_W)) u_tmr (
    .clock(clock), .rst(rst), .tick(tick), .load(ld), .load_value(ld_val),
    .value(timer), .expire(expire)
  );
  assign acc = state == PROG && key_valid && digit_ok(key_digit);
  assign lock_remaining = locked ? timer : '0;
  // Events are decided before expiry so a same-cycle tick never beats a transition or reload.
  always_comb begin
    nxt = state;
    ld = 1'b0;
    ld_val = '0;
    shadow_nxt = shadow;
    shadow_nxt[(NUM_DIGITS-1-int'(prog_idx))*DIGIT_W +: DIGIT_W] = key_digit;
    unique case (state)
      ARMED:
        if (attempt_done && attempt_ok) begin
          nxt = OPEN; ld = 1'b1; ld_val = TMR_W'(OPEN_TICKS);
        end else if (attempt_done && fail_count + 4'd1 == MF) begin
          nxt = LOCKOUT; ld = 1'b1; ld_val = TMR_W'(LOCK_TICKS);
        end
      OPEN:
        if (prog_req) begin
          nxt = PROG; ld = 1'b1; ld_val = TMR_W'(OPEN_TICKS);
        end else if (expire) nxt = ARMED;
      LOCKOUT: nxt = expire ? ARMED : LOCKOUT;
      PROG:
        if (key_valid) begin
          ld = 1'b1;
          ld_val = (acc && prog_idx != 2'(NUM_DIGITS-1)) ? TMR_W'(OPEN_TICKS) : '0;
          nxt = (acc && prog_idx != 2'(NUM_DIGITS-1)) ? PROG : ARMED;
        end else if (expire) nxt = ARMED;
      default: nxt = ARMED;
    endcase
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state <= ARMED;
      entry_enable <= 1'b1;
      admitted <= 1'b0;
      locked <= 1'b0;
      prog_active <= 1'b0;
      prog_idx <= '0;
      fail_count <= '0;
      shadow <= '0;
      pwd_code <= DEFAULT_CODE;
    end else begin
      state <= nxt;
      entry_enable <= nxt == ARMED;
      admitted <= nxt == OPEN;
      locked <= nxt == LOCKOUT;
      prog_active <= nxt == PROG;
      prog_idx <= nxt == PROG ? prog_idx + 2'(acc) : '0;
      if (state == ARMED && attempt_done) fail_count <= attempt_ok ? '0 : fail_count + 4'(fail_count != MF);
      else if (state == LOCKOUT && nxt == ARMED) fail_count <= '0;
      if (acc) shadow <= shadow_nxt;
      if (acc && prog_idx == 2'(NUM_DIGITS-1)) pwd_code <= shadow_nxt;
    end
endmodule
